put_enable: RTL and testbench
=============================

// Module: put_enable
// PURPOSE
//  Transmit side of the host stream link: the counterpart of the receive enable logic.
//  Collects result words from the accelerator result path and sends them to the host.
//  Uses a valid/ready stream with backpressure and asserts put_last on the final word.
//  Sits between the core result mux and the output DMA stream port.
// PARAMETERS
//  DATA_W  32  width of a result/stream word
//  DEPTH   4   entries in the internal output FIFO (power of 2, >=2)
//  LEN_W   16  width of the transfer length counter
// PORTS
//  clk        in   1       single clock, all logic on posedge
//  rst        in   1       asynchronous, active-high reset
//  run        in   1       accelerator run enable; low = abort/idle
//  put_start  in   1       pulse: start transfer of put_len words
//  put_len    in   LEN_W   number of words in the transfer, sampled on put_start
//  src_valid  in   1       result word available from core
//  src_data   in   DATA_W  result word
//  src_ready  out  1       word accepted from core this cycle (src_valid&src_ready)
//  put_valid  out  1       stream word valid to host
//  put_data   out  DATA_W  stream word
//  put_last   out  1       marks final word of the transfer
//  put_ready  in   1       host accepts word (put_valid&put_ready = handshake)
//  busy       out  1       transfer in progress (state != IDLE)
//  done       out  1       one-cycle pulse after final word handshake
// BEHAVIOUR
//  Reset: state=IDLE. FIFO empty, counters 0. All outputs 0 (src_ready, put_valid, put_data,
//   put_last, busy, done).
//  FSM states:
//  - IDLE -> SEND on put_start&run&put_len!=0. Latch in_rem=out_rem=put_len.
//  - IDLE with put_start&run&put_len==0: done pulses next cycle and state stays IDLE.
//  - put_start outside IDLE is ignored.
//  - SEND -> DONE on the handshake with out_rem==1.
//  - DONE -> IDLE unconditionally, with done=1 for exactly that one cycle.
//  Accept side:
//  - src_ready = (state==SEND) & run & ~fifo_full & (in_rem!=0).
//  - in_rem decrements on each src handshake.
//  - Words beyond put_len are never accepted.
//  Send side:
//  - put_valid = ~fifo_empty & state==SEND; put_data = FIFO head (first-word-fall-through).
//  - put_last = put_valid & (out_rem==1).
//  - Once put_valid is high, put_valid and put_data stay stable until put_ready, except on abort.
//  - out_rem decrements on each handshake.
//  Latency: word accepted in cycle N is visible on put_data in cycle N+1 (FIFO was empty).
//  Throughput: 1 word/cycle sustained with put_ready=1.
//  Boundaries:
//  - Simultaneous push and pop when full: push blocked (src_ready=0 when full). Pop proceeds.
//  - Simultaneous push and pop when empty: the pushed word appears next cycle. There is no bypass.
//  - FIFO pointers wrap modulo DEPTH. Use a count of LEN of $clog2(DEPTH)+1 bits for full/empty.
//  - put_ready held low: FIFO fills, src_ready drops, and no word is lost or duplicated.
//  Abort (run low in any state): next cycle state=IDLE, FIFO flushed, counters cleared,
//   put_valid=0, and done is not pulsed. This is the only case where put_valid drops without a handshake.
//  rst mid-transfer: immediate return to reset values.
// STRUCTURE
//  Shared package hpu_pkg:
//  - typedef enum logic[1:0] {PUT_IDLE, PUT_SEND, PUT_DONE} put_state_t
//  - default DATA_W and LEN_W constants
//  Sub-module put_fifo: synchronous FWFT FIFO with async rst and sync flush input.
//   Ports: push, pop, din, dout, full, empty.
//  Top level holds the FSM, both remaining-counters, and the handshake gating.
// TESTING
//  1. len=4, src words 0xA0..0xA3 back-to-back, put_ready=1 -> 4 beats in order.
//     put_last only on 0xA3. done pulses 1 cycle after that beat.
//  2. len=8, put_ready low for cycles 2..9 -> src_ready=0 once 4 are buffered.
//     Output order 0..7 is intact with no duplicates.
//  3. len=0 put_start -> no put_valid, done=1 next cycle, busy stays 0.
//  4. len=3, src offers 5 words -> only 3 accepted, src_ready=0 after the 3rd.
//     put_last on the 3rd.
//  5. run dropped after 2 of 6 beats -> put_valid=0 next cycle, no done.
//     A new len=2 transfer then sends cleanly.
//  6. Assert rst during SEND with a full FIFO -> all outputs 0 immediately.
//     After release the state is IDLE.

Source files
------------

// File: rtl/hpu_pkg.sv
// Shared types and default widths for the host-side stream blocks.
package hpu_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_LEN_W  = 16;
    localparam int DEFAULT_DEPTH  = 4;

    typedef enum logic [1:0] {
        PUT_IDLE,
        PUT_SEND,
        PUT_DONE
    } put_state_t;

endpackage

// File: rtl/put_enable_if.sv
// Result-in / stream-out handshake bundle of the transmit enable block.
interface put_enable_if import hpu_pkg::*; #(
    parameter int DATA_W = DEFAULT_DATA_W
);

    logic              src_valid;
    logic [DATA_W-1:0] src_data;
    logic              src_ready;
    logic              put_valid;
    logic [DATA_W-1:0] put_data;
    logic              put_last;
    logic              put_ready;

    // master is the transmit block itself; slave is the core/host environment
    modport master (
        input  src_valid, src_data, put_ready,
        output src_ready, put_valid, put_data, put_last
    );

    modport slave (
        output src_valid, src_data, put_ready,
        input  src_ready, put_valid, put_data, put_last
    );

endinterface

// File: rtl/put_fifo.sv
// First-word-fall-through FIFO: head word is visible on dout whenever not empty.
module put_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only; emptiness is tracked by count, so no reset needed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/put_enable.sv
// Transmit side of the host stream link: buffers core result words and streams
// exactly put_len of them to the host, flagging the final one with put_last.
module put_enable import hpu_pkg::*; #(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int LEN_W  = DEFAULT_LEN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             put_start,
    input  logic [LEN_W-1:0] put_len,
    put_enable_if.master     bus,
    output logic             busy,
    output logic             done
);

    put_state_t        state;
    logic [LEN_W-1:0]  in_rem;
    logic [LEN_W-1:0]  out_rem;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_dout;
    logic              accept;
    logic              send_valid;
    logic              accept_hs;
    logic              send_hs;
    logic              final_beat;

    assign accept     = (state == PUT_SEND) & run & ~fifo_full & (in_rem != '0);
    assign send_valid = ~fifo_empty & (state == PUT_SEND);
    assign accept_hs  = bus.src_valid & accept;
    assign send_hs    = send_valid & bus.put_ready;
    assign final_beat = (out_rem == LEN_W'(1));

    assign bus.src_ready = accept;
    assign bus.put_valid = send_valid;
    // Gate the head word so the stream reads zero whenever nothing is offered.
    assign bus.put_data  = send_valid ? fifo_dout : '0;
    assign bus.put_last  = send_valid & final_beat;

    put_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (~run),
        .push  (accept_hs),
        .pop   (send_hs),
        .din   (bus.src_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= PUT_IDLE;
            in_rem  <= '0;
            out_rem <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (!run) begin
            // Abort wins over everything, including a final handshake this cycle.
            state   <= PUT_IDLE;
            in_rem  <= '0;
            out_rem <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                PUT_IDLE: begin
                    if (put_start) begin
                        if (put_len != '0) begin
                            state   <= PUT_SEND;
                            in_rem  <= put_len;
                            out_rem <= put_len;
                            busy    <= 1'b1;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                PUT_SEND: begin
                    if (accept_hs) in_rem <= in_rem - 1'b1;
                    if (send_hs) begin
                        out_rem <= out_rem - 1'b1;
                        if (final_beat) begin
                            state <= PUT_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                PUT_DONE: begin
                    state <= PUT_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= PUT_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_put_enable.sv
// Directed bench for put_enable: hand-computed beats, latencies and boundaries.
module tb_put_enable;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        put_start;
    logic [15:0] put_len;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [31:0] beats[$];
    bit          lasts[$];
    bit          rdy_hist[64];
    bit          pv_hist[64];
    logic [31:0] pd_hist[64];
    int          accepted;
    int          done_cnt;
    int          done_cyc;
    int          last_cnt;

    put_enable_if #(.DATA_W(32)) bus ();

    put_enable #(
        .DATA_W (32),
        .DEPTH  (4),
        .LEN_W  (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .put_start (put_start),
        .put_len   (put_len),
        .bus       (bus),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Starts a transfer and runs max_cyc SEND-phase cycles, recording what the host sees.
    // Cycle 1 is the first cycle after put_start is taken.
    task automatic xfer(input int len, input logic [31:0] base, input int n_src,
                        input int stall_lo, input int stall_hi, input int abort_at,
                        input int max_cyc);
        int k;
        k = 0;
        beats.delete();
        lasts.delete();
        done_cnt = 0;
        done_cyc = 0;
        last_cnt = 0;
        run = 1'b1;
        put_start = 1'b1;
        put_len = 16'(len);
        bus.src_valid = 1'b0;
        bus.put_ready = 1'b1;
        tick();
        put_start = 1'b0;
        for (int c = 1; c <= max_cyc; c++) begin
            run = !(abort_at > 0 && c >= abort_at);
            bus.src_valid = (k < n_src);
            bus.src_data = base + 32'(k);
            bus.put_ready = !(c >= stall_lo && c <= stall_hi);
            #1;
            rdy_hist[c] = bus.src_ready;
            pv_hist[c] = bus.put_valid;
            pd_hist[c] = bus.put_data;
            if (done) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (bus.src_valid && bus.src_ready) k++;
            if (bus.put_valid && bus.put_ready) begin
                beats.push_back(bus.put_data);
                lasts.push_back(bus.put_last);
                if (bus.put_last) last_cnt++;
            end
            tick();
        end
        accepted = k;
        bus.src_valid = 1'b0;
        bus.put_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        run = 1'b0;
        put_start = 1'b0;
        put_len = '0;
        bus.src_valid = 1'b0;
        bus.src_data = '0;
        bus.put_ready = 1'b0;

        // Reset values
        tick();
        tick();
        chk("rst_src_ready", bus.src_ready, 0);
        chk("rst_put_valid", bus.put_valid, 0);
        chk("rst_put_data", bus.put_data, 0);
        chk("rst_put_last", bus.put_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        tick();

        // 1: len=4, back-to-back A0..A3
        xfer(4, 32'hA0, 4, 0, -1, 0, 10);
        chk("t1_pv_c1", pv_hist[1], 0);
        chk("t1_latency_pv", pv_hist[2], 1);
        chk("t1_latency_pd", pd_hist[2], 32'hA0);
        chk("t1_nbeats", beats.size(), 4);
        for (int i = 0; i < 4 && i < beats.size(); i++) begin
            chk($sformatf("t1_beat%0d", i), beats[i], 32'hA0 + 32'(i));
            chk($sformatf("t1_last%0d", i), lasts[i], (i == 3) ? 1 : 0);
        end
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_done_cyc", done_cyc, 6);
        chk("t1_busy_after", busy, 0);

        // 2: len=8 with host stalled for cycles 2..9
        xfer(8, 32'h0, 8, 2, 9, 0, 30);
        chk("t2_rdy_c4", rdy_hist[4], 1);
        chk("t2_rdy_c5_full", rdy_hist[5], 0);
        chk("t2_rdy_c9_full", rdy_hist[9], 0);
        chk("t2_pv_stall", pv_hist[7], 1);
        chk("t2_pd_stall", pd_hist[7], 0);
        chk("t2_accepted", accepted, 8);
        chk("t2_nbeats", beats.size(), 8);
        for (int i = 0; i < 8 && i < beats.size(); i++)
            chk($sformatf("t2_beat%0d", i), beats[i], 32'(i));
        chk("t2_last_cnt", last_cnt, 1);
        if (lasts.size() == 8) chk("t2_last_pos", lasts[7], 1);
        chk("t2_done_cnt", done_cnt, 1);

        // 3: zero-length start
        run = 1'b1;
        put_start = 1'b1;
        put_len = 16'd0;
        tick();
        put_start = 1'b0;
        #1;
        chk("t3_done", done, 1);
        chk("t3_busy", busy, 0);
        chk("t3_pv", bus.put_valid, 0);
        tick();
        chk("t3_done_drop", done, 0);
        chk("t3_busy2", busy, 0);

        // 4: len=3 while the core offers 5 words
        xfer(3, 32'h40, 5, 0, -1, 0, 10);
        chk("t4_accepted", accepted, 3);
        chk("t4_rdy_c3", rdy_hist[3], 1);
        chk("t4_rdy_c4", rdy_hist[4], 0);
        chk("t4_nbeats", beats.size(), 3);
        for (int i = 0; i < 3 && i < beats.size(); i++)
            chk($sformatf("t4_beat%0d", i), beats[i], 32'h40 + 32'(i));
        chk("t4_last_cnt", last_cnt, 1);
        if (lasts.size() == 3) chk("t4_last_pos", lasts[2], 1);
        chk("t4_done_cnt", done_cnt, 1);

        // 5: abort after 2 of 6 beats, then a clean len=2 transfer
        xfer(6, 32'h60, 6, 4, 4, 4, 10);
        chk("t5_nbeats", beats.size(), 2);
        if (beats.size() == 2) chk("t5_beat1", beats[1], 32'h61);
        chk("t5_pv_abort_cyc", pv_hist[4], 1);
        chk("t5_pv_after", pv_hist[5], 0);
        chk("t5_done_cnt", done_cnt, 0);
        chk("t5_busy", busy, 0);
        xfer(2, 32'h70, 2, 0, -1, 0, 8);
        chk("t5b_nbeats", beats.size(), 2);
        if (beats.size() == 2) begin
            chk("t5b_beat0", beats[0], 32'h70);
            chk("t5b_beat1", beats[1], 32'h71);
            chk("t5b_last", lasts[1], 1);
        end
        chk("t5b_done_cnt", done_cnt, 1);

        // 6: async reset mid-transfer with a full FIFO
        run = 1'b1;
        put_start = 1'b1;
        put_len = 16'd8;
        tick();
        put_start = 1'b0;
        bus.src_valid = 1'b1;
        bus.src_data = 32'h80;
        bus.put_ready = 1'b0;
        repeat (4) tick();
        #1;
        chk("t6_full_rdy", bus.src_ready, 0);
        chk("t6_full_pv", bus.put_valid, 1);
        chk("t6_busy", busy, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_rst_src_ready", bus.src_ready, 0);
        chk("t6_rst_put_valid", bus.put_valid, 0);
        chk("t6_rst_put_data", bus.put_data, 0);
        chk("t6_rst_put_last", bus.put_last, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_done", done, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("t6_idle_busy", busy, 0);
        chk("t6_idle_rdy", bus.src_ready, 0);
        chk("t6_idle_pv", bus.put_valid, 0);
        bus.src_valid = 1'b0;
        xfer(1, 32'h90, 1, 0, -1, 0, 6);
        chk("t6_post_nbeats", beats.size(), 1);
        if (beats.size() == 1) begin
            chk("t6_post_beat", beats[0], 32'h90);
            chk("t6_post_last", lasts[0], 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
